vga_sprite_grid: RTL and testbench

Parametrised VGA timing generator and sprite compositor for the whack-a-mole display. It draws one ROM-stored sprite at one of GRID_COLS x GRID_ROWS grid slots, chosen by a one-hot slot vector and a two-bank sprite mode. The block runs on the system clock with a pixel-enable strobe rather than a derived clock. Sprite ROM addresses come directly from pixel coordinates, and slot and mode changes are applied only at frame boundaries.

---
 rtl/vga_sprite_grid.sv | 184 ++++++++++++++++++
 tb/tb_vga_sprite_grid.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_sprite_grid.sv
// VGA timing generator with a single ROM sprite placed on a slot grid.
// Runs on the system clock; pix_en advances timing and the two-stage pixel pipeline.
module vga_sprite_grid #(
   parameter int          H_SYNC    = 96,
   parameter int          H_BP      = 48,
   parameter int          H_ACT     = 640,
   parameter int          H_FP      = 16,
   parameter int          V_SYNC    = 2,
   parameter int          V_BP      = 33,
   parameter int          V_ACT     = 480,
   parameter int          V_FP      = 10,
   parameter int          SPR_W     = 128,
   parameter int          SPR_H     = 128,
   parameter int          GRID_COLS = 4,
   parameter int          GRID_ROWS = 2,
   parameter int          GRID_X0   = 0,
   parameter int          GRID_Y0   = 128,
   parameter int          PITCH_X   = 129,
   parameter int          PITCH_Y   = 129,
   parameter logic [15:0] BG_COLOR  = 16'h0000,
   parameter logic [15:0] TRANS_KEY = 16'hF81F
) (
   input  logic                                        clk,
   input  logic                                        rst_n,
   input  logic                                        pix_en,
   input  logic [GRID_COLS*GRID_ROWS-1:0]              slot_sel,
   input  logic                                        spr_bank,
   output logic [$clog2(SPR_W)+$clog2(SPR_H):0]        rom_addr,
   input  logic [15:0]                                 rom_data,
   output logic [4:0]                                  vga_r,
   output logic [5:0]                                  vga_g,
   output logic [4:0]                                  vga_b,
   output logic                                        vga_hs,
   output logic                                        vga_vs,
   output logic                                        vga_de,
   output logic                                        frame_start
);

   localparam int H_TOT = H_SYNC + H_BP + H_ACT + H_FP;
   localparam int V_TOT = V_SYNC + V_BP + V_ACT + V_FP;
   localparam int HW    = $clog2(H_TOT);
   localparam int VW    = $clog2(V_TOT);
   localparam int XW    = $clog2(SPR_W);
   localparam int YW    = $clog2(SPR_H);
   localparam int AW    = 1 + XW + YW;
   localparam int NSLOT = GRID_COLS * GRID_ROWS;
   localparam int CW    = 16;

   logic [HW-1:0]    h_cnt_q, h_cnt_d;
   logic [VW-1:0]    v_cnt_q, v_cnt_d;
   logic [NSLOT-1:0] slot_q, slot_d;
   logic             bank_q, bank_d;
   logic             frame_start_q, frame_start_d;
   logic [AW-1:0]    rom_addr_q, rom_addr_d;
   logic             hit1_q, hit1_d;
   logic             act1_q, act1_d;
   logic             hs1_q, hs1_d;
   logic             vs1_q, vs1_d;
   logic [15:0]      rgb_q, rgb_d;
   logic             hs_q, hs_d;
   logic             vs_q, vs_d;
   logic             de_q, de_d;

   logic             hidden_s;
   int               idx_s;
   logic [CW-1:0]    sx_s, sy_s, x_s, y_s, dx_s, dy_s;
   logic             h_act_s, v_act_s, act_s, hit_s;

   // Slot decode of the frame-latched request plus per-pixel sprite hit test.
   always_comb begin
      hidden_s = (slot_q == {NSLOT{1'b0}});
      idx_s    = 0;
      for (int i = NSLOT - 1; i >= 0; i--) begin
         idx_s = slot_q[i] ? i : idx_s;
      end
      sx_s    = CW'(GRID_X0 + (idx_s % GRID_COLS) * PITCH_X);
      sy_s    = CW'(GRID_Y0 + (idx_s / GRID_COLS) * PITCH_Y);
      x_s     = CW'(h_cnt_q) - CW'(H_SYNC + H_BP);
      y_s     = CW'(v_cnt_q) - CW'(V_SYNC + V_BP);
      dx_s    = x_s - sx_s;
      dy_s    = y_s - sy_s;
      h_act_s = (h_cnt_q >= HW'(H_SYNC + H_BP)) && (h_cnt_q < HW'(H_SYNC + H_BP + H_ACT));
      v_act_s = (v_cnt_q >= VW'(V_SYNC + V_BP)) && (v_cnt_q < VW'(V_SYNC + V_BP + V_ACT));
      act_s   = h_act_s && v_act_s;
      hit_s   = !hidden_s && act_s &&
                (x_s >= sx_s) && (dx_s < CW'(SPR_W)) &&
                (y_s >= sy_s) && (dy_s < CW'(SPR_H));
   end

   // Next-state for counters, frame latch and both pipeline stages.
   always_comb begin
      h_cnt_d       = h_cnt_q;
      v_cnt_d       = v_cnt_q;
      slot_d        = slot_q;
      bank_d        = bank_q;
      rom_addr_d    = rom_addr_q;
      hit1_d        = hit1_q;
      act1_d        = act1_q;
      hs1_d         = hs1_q;
      vs1_d         = vs1_q;
      rgb_d         = rgb_q;
      hs_d          = hs_q;
      vs_d          = vs_q;
      de_d          = de_q;
      frame_start_d = pix_en && (h_cnt_q == HW'(0)) && (v_cnt_q == VW'(0));
      if (pix_en) begin
         if (h_cnt_q == HW'(H_TOT - 1)) begin
            h_cnt_d = HW'(0);
            v_cnt_d = (v_cnt_q == VW'(V_TOT - 1)) ? VW'(0) : v_cnt_q + VW'(1);
         end else begin
            h_cnt_d = h_cnt_q + HW'(1);
         end
         if (frame_start_d) begin
            slot_d = slot_sel;
            bank_d = spr_bank;
         end else begin
            slot_d = slot_q;
         end
         // Address comes straight from the pixel offset; it holds outside the sprite.
         rom_addr_d = hit_s ? {bank_q, dy_s[YW-1:0], dx_s[XW-1:0]} : rom_addr_q;
         hit1_d     = hit_s;
         act1_d     = act_s;
         hs1_d      = (h_cnt_q >= HW'(H_SYNC));
         vs1_d      = (v_cnt_q >= VW'(V_SYNC));
         if (hit1_q) begin
            rgb_d = (rom_data == TRANS_KEY) ? BG_COLOR : rom_data;
         end else if (act1_q) begin
            rgb_d = BG_COLOR;
         end else begin
            rgb_d = 16'h0000;
         end
         hs_d = hs1_q;
         vs_d = vs1_q;
         de_d = act1_q;
      end else begin
         h_cnt_d = h_cnt_q;
      end
   end

   // State register; asynchronous reset returns the whole frame to its start.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h_cnt_q       <= '0;
         v_cnt_q       <= '0;
         slot_q        <= '0;
         bank_q        <= 1'b0;
         frame_start_q <= 1'b0;
         rom_addr_q    <= '0;
         hit1_q        <= 1'b0;
         act1_q        <= 1'b0;
         hs1_q         <= 1'b1;
         vs1_q         <= 1'b1;
         rgb_q         <= 16'h0000;
         hs_q          <= 1'b1;
         vs_q          <= 1'b1;
         de_q          <= 1'b0;
      end else begin
         h_cnt_q       <= h_cnt_d;
         v_cnt_q       <= v_cnt_d;
         slot_q        <= slot_d;
         bank_q        <= bank_d;
         frame_start_q <= frame_start_d;
         rom_addr_q    <= rom_addr_d;
         hit1_q        <= hit1_d;
         act1_q        <= act1_d;
         hs1_q         <= hs1_d;
         vs1_q         <= vs1_d;
         rgb_q         <= rgb_d;
         hs_q          <= hs_d;
         vs_q          <= vs_d;
         de_q          <= de_d;
      end
   end

   assign rom_addr    = rom_addr_q;
   assign vga_r       = rgb_q[15:11];
   assign vga_g       = rgb_q[10:5];
   assign vga_b       = rgb_q[4:0];
   assign vga_hs      = hs_q;
   assign vga_vs      = vs_q;
   assign vga_de      = de_q;
   assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sprite_grid.sv
// Scoreboard bench for vga_sprite_grid on a shrunken timing so whole frames fit the run.
module tb_vga_sprite_grid;

   localparam int HS = 4, HB = 3, HA = 40, HF = 2;
   localparam int VS = 2, VB = 2, VA = 30, VF = 1;
   localparam int HT = HS + HB + HA + HF;
   localparam int VT = VS + VB + VA + VF;
   localparam int FR = HT * VT;
   localparam int SW = 8, SH = 4;
   localparam int GX0 = 6, GY0 = 5, PX = 9, PY = 10;
   localparam logic [15:0] BG  = 16'h0841;
   localparam logic [15:0] KEY = 16'hF81F;

   typedef struct packed {
      logic [15:0] rgb;
      logic        hs;
      logic        vs;
      logic        de;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        pix_en;
   logic [7:0]  slot_sel;
   logic        spr_bank;
   logic [5:0]  rom_addr;
   logic [15:0] rom_data = 16'h0000;
   logic [4:0]  vga_r;
   logic [5:0]  vga_g;
   logic [4:0]  vga_b;
   logic        vga_hs, vga_vs, vga_de, frame_start;

   int   n_checks = 0;
   int   n_errors = 0;
   int   m_h, m_v, n_strobe;
   logic [7:0] m_slot;
   logic       m_bank;
   logic [5:0] m_addr;
   exp_t       q[$];
   exp_t       last;
   bit         cnt_en;
   int         cnt_de, cnt_hs, cnt_vs, cnt_fs;

   vga_sprite_grid #(
      .H_SYNC(HS), .H_BP(HB), .H_ACT(HA), .H_FP(HF),
      .V_SYNC(VS), .V_BP(VB), .V_ACT(VA), .V_FP(VF),
      .SPR_W(SW), .SPR_H(SH), .GRID_COLS(4), .GRID_ROWS(2),
      .GRID_X0(GX0), .GRID_Y0(GY0), .PITCH_X(PX), .PITCH_Y(PY),
      .BG_COLOR(BG), .TRANS_KEY(KEY)
   ) dut (
      .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .slot_sel(slot_sel),
      .spr_bank(spr_bank), .rom_addr(rom_addr), .rom_data(rom_data),
      .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .vga_hs(vga_hs),
      .vga_vs(vga_vs), .vga_de(vga_de), .frame_start(frame_start)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] rom_f(input logic [5:0] a);
      if (a == 6'd10 || a == 6'd45) return KEY;
      return {a, ~a, 4'hA};
   endfunction

   // Synchronous sprite ROM, one clock of latency.
   always @(posedge clk) rom_data <= rom_f(rom_addr);

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %h exp %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_h = 0; m_v = 0; m_slot = 8'h00; m_bank = 1'b0; m_addr = 6'd0;
      n_strobe = 0;
      q.delete();
      last = '{rgb: 16'h0000, hs: 1'b1, vs: 1'b1, de: 1'b0};
   endtask

   task automatic check_outputs();
      check_eq("rgb", {vga_r, vga_g, vga_b}, last.rgb);
      check_eq("hs", vga_hs, last.hs);
      check_eq("vs", vga_vs, last.vs);
      check_eq("de", vga_de, last.de);
      check_eq("rom_addr", rom_addr, m_addr);
   endtask

   task automatic tick(input bit strobe);
      exp_t e;
      bit   fs_exp, act, hit;
      int   x, y, sx, sy, idx;
      logic [15:0] rd;
      fs_exp = 1'b0;
      pix_en = strobe;
      if (strobe) begin
         x = m_h - (HS + HB);
         y = m_v - (VS + VB);
         act = (x >= 0 && x < HA && y >= 0 && y < VA);
         idx = -1;
         for (int i = 7; i >= 0; i--) if (m_slot[i]) idx = i;
         hit = 1'b0;
         if (idx >= 0 && act) begin
            sx  = GX0 + (idx % 4) * PX;
            sy  = GY0 + (idx / 4) * PY;
            hit = (x >= sx && x < sx + SW && y >= sy && y < sy + SH);
            if (hit) m_addr = 6'(int'(m_bank) * 32 + (y - sy) * 8 + (x - sx));
         end
         rd = rom_f(m_addr);
         e.rgb = hit ? ((rd == KEY) ? BG : rd) : (act ? BG : 16'h0000);
         e.hs  = (m_h >= HS);
         e.vs  = (m_v >= VS);
         e.de  = act;
         q.push_back(e);
         fs_exp = (m_h == 0 && m_v == 0);
         if (fs_exp) begin
            m_slot = slot_sel;
            m_bank = spr_bank;
         end
         if (m_h == HT - 1) begin
            m_h = 0;
            m_v = (m_v == VT - 1) ? 0 : m_v + 1;
         end else begin
            m_h = m_h + 1;
         end
         n_strobe++;
      end
      @(posedge clk);
      #1;
      check_eq("frame_start", frame_start, fs_exp);
      if (strobe && q.size() >= 2) last = q.pop_front();
      check_outputs();
      if (cnt_en) begin
         if (strobe && n_strobe >= 2 && n_strobe < 2 * FR + 2) begin
            cnt_de += vga_de ? 1 : 0;
            cnt_hs += vga_hs ? 0 : 1;
            cnt_vs += vga_vs ? 0 : 1;
         end
         if (n_strobe >= 1 && n_strobe <= 2 * FR) cnt_fs += frame_start ? 1 : 0;
      end
      @(negedge clk);
      pix_en = 1'b0;
   endtask

   task automatic run_strobes(input int n);
      for (int i = 0; i < n; i++) begin
         tick(1'b1);
         repeat ($urandom_range(1, 2)) tick(1'b0);
      end
   endtask

   task automatic check_reset_state();
      check_eq("rst_rgb", {vga_r, vga_g, vga_b}, 16'h0000);
      check_eq("rst_hs", vga_hs, 1'b1);
      check_eq("rst_vs", vga_vs, 1'b1);
      check_eq("rst_de", vga_de, 1'b0);
      check_eq("rst_fs", frame_start, 1'b0);
      check_eq("rst_addr", rom_addr, 6'd0);
   endtask

   initial begin
      rst_n = 1'b0; pix_en = 1'b0; slot_sel = 8'h00; spr_bank = 1'b0;
      cnt_en = 1'b0; cnt_de = 0; cnt_hs = 0; cnt_vs = 0; cnt_fs = 0;
      model_reset();
      repeat (3) @(negedge clk);
      check_reset_state();

      // Slot 0 bank 0, then slot 5 bank 1; both frames feed the timing counts.
      slot_sel = 8'h01; spr_bank = 1'b0; rst_n = 1'b1; cnt_en = 1'b1;
      run_strobes(FR);
      slot_sel = 8'h20; spr_bank = 1'b1;
      run_strobes(FR);
      slot_sel = 8'h00; spr_bank = 1'b0;
      run_strobes(2);
      cnt_en = 1'b0;
      check_eq("de_count", cnt_de, 2 * HA * VA);
      check_eq("hs_low_count", cnt_hs, 2 * VT * HS);
      check_eq("vs_low_count", cnt_vs, 2 * VS * HT);
      check_eq("fs_count", cnt_fs, 2);
      run_strobes(FR - 2);

      // Multi-hot request (lowest wins) and a slot clipped at the right edge.
      slot_sel = 8'h12; run_strobes(FR);
      slot_sel = 8'h80; spr_bank = 1'b1; run_strobes(FR);

      // Mid-frame request change must wait for the next frame.
      slot_sel = 8'h01; spr_bank = 1'b0; run_strobes(20 * HT);
      slot_sel = 8'h08; spr_bank = 1'b1; run_strobes(FR - 20 * HT);
      run_strobes(FR);

      // Reset mid-frame, then restart from count 0.
      run_strobes(15 * HT + 7);
      rst_n = 1'b0;
      #1;
      check_reset_state();
      repeat (3) begin
         @(negedge clk);
         check_reset_state();
      end
      model_reset();
      slot_sel = 8'h04; spr_bank = 1'b0; rst_n = 1'b1;
      run_strobes(FR + 10);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
